// File: rtl/processor_pkg.sv
// Shared types and defaults for the processor's serial result link.
package processor_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, HOLD} tx_state_t;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/tx_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, Tick marks the last cycle of a bit.
module tx_baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Clr,
    output logic Tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign Tick = (count_q == CNT_LAST);

    // With CLKS_PER_BIT=1 the count never leaves 0, so Tick is high every cycle.
    always_comb begin
        count_d = count_q + 1'b1;
        if (Clr || Tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/processor_uart_tx.sv
// Sends result registers A then B as two back-to-back 8N1 frames on TxD per Send press.
module processor_uart_tx
    import processor_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Send,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              TxD,
    output logic              Busy,
    output logic              Done
);

    localparam int unsigned BIDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_W - 1);

    tx_state_t state_q, state_d;

    logic [BIDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic                word_sel_q, word_sel_d;
    logic [2*DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0]   word_d;
    logic                txd_q, txd_d;
    logic                done_q, done_d;
    logic                tick;
    logic                cnt_clr;

    assign cnt_clr = (state_q == IDLE) || (state_q == HOLD);

    tx_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .Clk  (Clk),
        .Reset(Reset),
        .Clr  (cnt_clr),
        .Tick (tick)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (Send) state_d = START;
            START:   if (tick) state_d = DATA;
            DATA:    if (tick && (bit_idx_q == BIDX_LAST)) state_d = STOP;
            STOP:    if (tick) state_d = word_sel_q ? HOLD : START;
            HOLD:    if (!Send) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next state: shadow capture on accept, bit/word stepping at bit ends.
    always_comb begin
        shadow_d   = shadow_q;
        word_sel_d = word_sel_q;
        bit_idx_d  = bit_idx_q;
        if ((state_q == IDLE) && Send) begin
            shadow_d   = {B, A};
            word_sel_d = 1'b0;
            bit_idx_d  = '0;
        end
        if ((state_q == DATA) && tick) begin
            bit_idx_d = (bit_idx_q == BIDX_LAST) ? '0 : bit_idx_q + 1'b1;
        end
        if ((state_q == STOP) && tick && !word_sel_q) begin
            word_sel_d = 1'b1;
        end
    end

    // TxD is registered from the next-state view so the line changes on the bit edge itself.
    always_comb begin
        word_d = word_sel_d ? shadow_d[2*DATA_W-1:DATA_W] : shadow_d[DATA_W-1:0];
        txd_d  = 1'b1;
        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = word_d[bit_idx_d];
            default: txd_d = 1'b1;
        endcase
        done_d = (state_q == STOP) && tick && word_sel_q;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            shadow_q   <= '0;
            word_sel_q <= 1'b0;
            bit_idx_q  <= '0;
            txd_q      <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            word_sel_q <= word_sel_d;
            bit_idx_q  <= bit_idx_d;
            txd_q      <= txd_d;
            done_q     <= done_d;
        end
    end

    assign TxD  = txd_q;
    assign Done = done_q;
    assign Busy = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_processor_uart_tx.sv
// Bench for processor_uart_tx: per-cycle TxD scoreboard at 4 and 1 clocks per bit.
module tb_processor_uart_tx;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [0:9] fa;  // expected A frame bits in line order
        logic [0:9] fb;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] send_v = 2'b00;
    logic [7:0] a_v [2];
    logic [7:0] b_v [2];
    logic       txd4, busy4, done4;
    logic       txd1, busy1, done1;

    logic       exp_q [$];
    int         vec_cnt = 0;
    int         miss_cnt = 0;
    vec_t       tbl [4];

    always #5 clk = ~clk;

    processor_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (
        .Clk  (clk),
        .Reset(rst_n),
        .Send (send_v[0]),
        .A    (a_v[0]),
        .B    (b_v[0]),
        .TxD  (txd4),
        .Busy (busy4),
        .Done (done4)
    );

    processor_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .Clk  (clk),
        .Reset(rst_n),
        .Send (send_v[1]),
        .A    (a_v[1]),
        .B    (b_v[1]),
        .TxD  (txd1),
        .Busy (busy1),
        .Done (done1)
    );

    function automatic logic txd_of(input int u);
        return (u == 0) ? txd4 : txd1;
    endfunction

    function automatic logic busy_of(input int u);
        return (u == 0) ? busy4 : busy1;
    endfunction

    function automatic logic done_of(input int u);
        return (u == 0) ? done4 : done1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_idle(input int u, input string tag);
        chk({tag, "_txd"}, 32'(txd_of(u)), 32'd1);
        chk({tag, "_busy"}, 32'(busy_of(u)), 32'd0);
        chk({tag, "_done"}, 32'(done_of(u)), 32'd0);
    endtask

    // Called at posedge+1; the next posedge is the accept edge.
    task automatic run_xfer(input int u, input int cpb, input vec_t v, input bit hold_send,
                            input int mod_a_cyc, input int abort_cyc);
        int   total;
        logic e;
        total    = 20 * cpb;
        a_v[u]   = v.a;
        b_v[u]   = v.b;
        send_v[u] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            for (int c = 0; c < cpb; c++) begin
                exp_q.push_back((k < 10) ? v.fa[k] : v.fb[k - 10]);
            end
        end
        @(posedge clk); #1;
        if (!hold_send) send_v[u] = 1'b0;
        for (int n = 0; n < total; n++) begin
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            chk($sformatf("txd_u%0d_c%0d", u, n), 32'(txd_of(u)), 32'(e));
            chk($sformatf("busy_u%0d_c%0d", u, n), 32'(busy_of(u)), 32'd1);
            chk($sformatf("done_u%0d_c%0d", u, n), 32'(done_of(u)), 32'd0);
            if (n == mod_a_cyc) a_v[u] = 8'hFF;
            if (n == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                chk_idle(u, "abort");
                exp_q.delete();
                send_v[u] = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("busy_fall", 32'(busy_of(u)), 32'd0);
        chk("done_pulse", 32'(done_of(u)), 32'd1);
        chk("end_txd", 32'(txd_of(u)), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk_idle(u, "after_done");
        @(posedge clk); #1;
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        tbl[0] = '{8'h5A, 8'hC3, 10'b0010110101, 10'b0110000111};
        tbl[1] = '{8'h00, 8'hFF, 10'b0000000001, 10'b0111111111};
        tbl[2] = '{8'h01, 8'h80, 10'b0100000001, 10'b0000000011};
        tbl[3] = '{8'hA5, 8'h3C, 10'b0101001011, 10'b0001111001};
        a_v[0] = '0; a_v[1] = '0;
        b_v[0] = '0; b_v[1] = '0;

        // Reset held for 3 cycles, then released.
        #2 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle(0, "rst4");
            chk_idle(1, "rst1");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_idle(0, "post_rst4");
            chk_idle(1, "post_rst1");
        end
        @(posedge clk); #1;

        // Table-driven transfers at both bit rates.
        for (int i = 0; i < 4; i++) begin
            run_xfer(0, 4, tbl[i], 1'b0, -1, -1);
            run_xfer(1, 1, tbl[i], 1'b0, -1, -1);
        end

        // Send held through the transfer: one transfer, then HOLD until release.
        run_xfer(0, 4, tbl[3], 1'b1, -1, -1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_idle(0, "hold");
            @(posedge clk); #1;
        end
        send_v[0] = 1'b0;
        @(posedge clk); #1;
        run_xfer(0, 4, tbl[1], 1'b0, -1, -1);

        // A overwritten during its data bits; frame still carries the captured value.
        run_xfer(0, 4, tbl[0], 1'b0, 12, -1);

        // Reset during B data bit 3, then a full fresh transfer.
        run_xfer(0, 4, tbl[0], 1'b0, -1, 58);
        @(negedge clk);
        chk_idle(0, "post_abort");
        @(posedge clk); #1;
        run_xfer(0, 4, tbl[0], 1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
